// File: rtl/sequencia_pkg.sv
// -----------------------------------------------------------------------------
// sequencia_pkg
// Shared definitions for the parametrised sequence game.
//   estado_t : FSM state encoding. The numeric codes are visible on db_estado,
//              so the board's hexa7seg decoder shows them directly.
//   addr_w() : address width for a given number of words. It never returns 0,
//              so a one-word ROM still gets a 1-bit address.
// -----------------------------------------------------------------------------
package sequencia_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    PREPARACAO   = 4'h1,
    ESPERA       = 4'h2,
    REGISTRA     = 4'h4,
    COMPARA      = 4'h5,
    PROXIMO      = 4'h6,
    ESPERA_SOLTA = 4'h7,
    FIM_ACERTO   = 4'hA,
    FIM_TIMEOUT  = 4'hD,
    FIM_ERRO     = 4'hE
  } estado_t;

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rom_sequencia_param.sv
// -----------------------------------------------------------------------------
// rom_sequencia_param
// Asynchronous-read ROM that holds the expected sequence of plays.
// Contents: word[k] = 1 << (k mod DATA_W), which gives a walking one
// (0001, 0010, 0100, 1000, 0001, ... for DATA_W = 4).
// Ports:
//   addr  in  ADDR_W  word address
//   data  out DATA_W  word at addr (0 for addresses beyond DEPTH-1)
// -----------------------------------------------------------------------------
module rom_sequencia_param
  import sequencia_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    assign rom[k] = DATA_W'(1) << (k % DATA_W);
  end

  // When DEPTH is not a power of two, some addresses have no word behind them.
  always_comb begin
    data = '0;
    if (32'(addr) < DEPTH) data = rom[addr];
  end

endmodule

// File: rtl/circuito_sequencia_param.sv
// -----------------------------------------------------------------------------
// circuito_sequencia_param
// Sequence-memory game. Each press on chaves is registered as one play and
// compared with the current ROM word. A mismatch ends the round. The round
// also ends after N_JOGADAS correct plays.
//
// Optional feature: define TIMEOUT_EN to add an idle timer in ESPERA. The
// round ends in FIM_TIMEOUT after TIMEOUT_CYCLES cycles with no play.
//
// Ports:
//   clock        in   1       rising-edge clock
//   reset        in   1       asynchronous, active-low
//   iniciar      in   1       start/restart (used only in INICIAL and FIM_*)
//   chaves       in   DATA_W  player input; a non-zero value is a play
//   pronto       out  1       round finished
//   acertou      out  1       round finished with all plays correct
//   errou        out  1       round finished by mismatch or timeout
//   timeout      out  1       round finished by timeout (0 without TIMEOUT_EN)
//   db_igual     out  1       registered compare result of the last play
//   db_iniciar   out  1       copy of iniciar
//   db_contagem  out  ADDR_W  current ROM address
//   db_memoria   out  DATA_W  ROM word at db_contagem
//   db_jogada    out  DATA_W  registered play
//   db_estado    out  4       FSM state code
//
// Handshake: there is no valid/ready pair. A play is "valid" while chaves is
// non-zero and is consumed once. ESPERA_SOLTA waits for chaves to return to
// zero, so a held press cannot be counted twice.
// -----------------------------------------------------------------------------
module circuito_sequencia_param
  import sequencia_pkg::*;
#(
  parameter int DATA_W         = 4,
  parameter int DEPTH          = 16,
  parameter int N_JOGADAS      = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] chaves,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              db_igual,
  output logic              db_iniciar,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_memoria,
  output logic [DATA_W-1:0] db_jogada,
  output logic [3:0]        db_estado
);

  // The address counter has no wrap logic. It relies on this bound to stay
  // inside the ROM.
  if (N_JOGADAS < 1 || N_JOGADAS > DEPTH) begin : g_bad_jogadas
    $error("N_JOGADAS must be in 1..DEPTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  estado_t           estado, prox_estado;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] jogada;
  logic              igual;
  logic [DATA_W-1:0] memoria;
  logic              jogada_presente;
  logic              ultimo;
  logic              expirou;

  rom_sequencia_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rom (
    .addr (endereco),
    .data (memoria)
  );

  assign jogada_presente = (chaves != '0);
  assign ultimo          = (endereco == ADDR_W'(N_JOGADAS - 1));

`ifdef TIMEOUT_EN
  localparam int TIMER_W = addr_w(TIMEOUT_CYCLES);
  logic [TIMER_W-1:0] timer;

  // The timer runs only in ESPERA. Any other state clears it, PREPARACAO
  // included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                timer <= '0;
    else if (estado == ESPERA) timer <= timer + TIMER_W'(1);
    else                       timer <= '0;
  end

  assign expirou = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
  assign expirou = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox_estado;
  end

  // Next-state logic. In ESPERA, a play takes priority over timer expiry.
  always_comb begin
    prox_estado = estado;
    case (estado)
      INICIAL:      if (iniciar) prox_estado = PREPARACAO;
      PREPARACAO:   prox_estado = ESPERA;
      ESPERA: begin
        if (jogada_presente) prox_estado = REGISTRA;
        else if (expirou)    prox_estado = FIM_TIMEOUT;
      end
      REGISTRA:     prox_estado = COMPARA;
      COMPARA: begin
        if (jogada != memoria) prox_estado = FIM_ERRO;
        else if (ultimo)       prox_estado = FIM_ACERTO;
        else                   prox_estado = PROXIMO;
      end
      PROXIMO:      prox_estado = ESPERA_SOLTA;
      ESPERA_SOLTA: if (!jogada_presente) prox_estado = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                    if (iniciar) prox_estado = PREPARACAO;
      default:      prox_estado = INICIAL;
    endcase
  end

  // Datapath registers, steered directly by the current state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco <= '0;
      jogada   <= '0;
      igual    <= 1'b0;
    end else begin
      case (estado)
        PREPARACAO: begin
          endereco <= '0;
          jogada   <= '0;
          igual    <= 1'b0;
        end
        REGISTRA: jogada   <= chaves;
        COMPARA:  igual    <= (jogada == memoria);
        PROXIMO:  endereco <= endereco + ADDR_W'(1);
        default:  ;
      endcase
    end
  end

  // Moore flags, decoded from the registered state only.
  always_comb begin
    pronto  = 1'b0;
    acertou = 1'b0;
    errou   = 1'b0;
    timeout = 1'b0;
    case (estado)
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_igual    = igual;
  assign db_iniciar  = iniciar;
  assign db_contagem = endereco;
  assign db_memoria  = memoria;
  assign db_jogada   = jogada;
  assign db_estado   = estado;

endmodule

// File: tb/tb_circuito_sequencia_param.sv
// -----------------------------------------------------------------------------
// tb_circuito_sequencia_param
// Directed bench for circuito_sequencia_param (DATA_W=4, DEPTH=16,
// N_JOGADAS=16, TIMEOUT_CYCLES=10). A reference model of the ROM and address
// computes each play's expected verdict when the play is driven. A monitor
// compares that verdict when the FSM leaves COMPARA. The timeout scenario
// runs only when TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_circuito_sequencia_param;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int NJ     = 16;
  localparam int TOC    = 10;
  localparam int ADDR_W = 4;
  localparam int EW     = 4 + 1 + DATA_W + ADDR_W;  // {state, igual, jogada, addr}

  localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_ESP = 4'h2, S_REG = 4'h4,
                         S_CMP = 4'h5, S_PROX = 4'h6, S_SOLTA = 4'h7,
                         S_ACE = 4'hA, S_TMO = 4'hD, S_ERR = 4'hE;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic [DATA_W-1:0] chaves;
  logic              pronto, acertou, errou, timeout, db_igual, db_iniciar;
  logic [ADDR_W-1:0] db_contagem;
  logic [DATA_W-1:0] db_memoria, db_jogada;
  logic [3:0]        db_estado;

  int n_cmp = 0;
  int n_err = 0;
  int m_addr = 0;
  logic [EW-1:0] exp_q[$];
  logic [3:0]    prev_st = 4'h0;

  circuito_sequencia_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .N_JOGADAS(NJ), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_igual(db_igual), .db_iniciar(db_iniciar), .db_contagem(db_contagem),
    .db_memoria(db_memoria), .db_jogada(db_jogada), .db_estado(db_estado)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] code, input string tag);
    int n = 0;
    while (db_estado !== code && n < 50) begin
      step();
      n++;
    end
    chk(tag, {28'd0, db_estado}, {28'd0, code});
  endtask

  // Reference model: ROM word k is 1 << (k mod 4). The address advances after
  // every correct play except the last one.
  task automatic push_exp(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] word;
    logic [3:0]        st;
    logic              eq;
    word = DATA_W'(1 << (m_addr % DATA_W));
    eq   = (v == word);
    if (!eq)              st = S_ERR;
    else if (m_addr == NJ - 1) st = S_ACE;
    else                  st = S_PROX;
    exp_q.push_back({st, eq, v, ADDR_W'(m_addr)});
    if (st == S_PROX) m_addr++;
  endtask

  task automatic play(input logic [DATA_W-1:0] v, input int hold);
    wait_state(S_ESP, "wait_espera");
    push_exp(v);
    chaves = v;
    repeat (hold) step();
    chaves = '0;
  endtask

  task automatic restart();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("prep_state", {28'd0, db_estado}, {28'd0, S_PREP});
    chk("prep_pronto", {31'd0, pronto}, 32'd0);
    m_addr = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset === 1'b1 && prev_st == S_CMP && db_estado !== S_CMP) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL verdict_queue observed=empty expected=entry");
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("verdict_state",  {28'd0, db_estado},   {28'd0, e[EW-1 -: 4]});
        chk("verdict_igual",  {31'd0, db_igual},    {31'd0, e[DATA_W+ADDR_W]});
        chk("verdict_jogada", {28'd0, db_jogada},   {28'd0, e[ADDR_W +: DATA_W]});
        chk("verdict_addr",   {28'd0, db_contagem}, {28'd0, e[ADDR_W-1:0]});
      end
    end
    prev_st <= db_estado;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    reset = 1'b0; iniciar = 1'b0; chaves = '0;

    // 1: reset and idle
    step();
    chk("rst_state", {28'd0, db_estado}, {28'd0, S_INI});
    reset = 1'b1;
    repeat (5) step();
    chk("idle_state",   {28'd0, db_estado},   {28'd0, S_INI});
    chk("idle_flags",   {28'd0, pronto, acertou, errou, timeout}, 32'd0);
    chk("idle_addr",    {28'd0, db_contagem}, 32'd0);
    chk("idle_jogada",  {28'd0, db_jogada},   32'd0);
    chk("idle_igual",   {31'd0, db_igual},    32'd0);
    chk("idle_memoria", {28'd0, db_memoria},  32'd1);

    // 2: full correct round; iniciar is pulsed mid-round and must be ignored
    restart();
    step();
    chk("espera_state", {28'd0, db_estado}, {28'd0, S_ESP});
    for (int i = 0; i < NJ; i++) begin
      play(seq[i % 4], 2);
      if (i == 4) begin
        wait_state(S_ESP, "ign_wait");
        iniciar = 1'b1;
        step();
        chk("ign_state",      {28'd0, db_estado},   {28'd0, S_ESP});
        chk("ign_addr",       {28'd0, db_contagem}, 32'd5);
        chk("ign_db_iniciar", {31'd0, db_iniciar},  32'd1);
        iniciar = 1'b0;
      end
    end
    wait_state(S_ACE, "ace_wait");
    repeat (3) step();
    chk("ace_state",   {28'd0, db_estado},   {28'd0, S_ACE});
    chk("ace_flags",   {28'd0, pronto, acertou, errou, timeout}, 32'b1100);
    chk("ace_addr",    {28'd0, db_contagem}, 32'd15);
    chk("ace_igual",   {31'd0, db_igual},    32'd1);
    chk("ace_memoria", {28'd0, db_memoria},  32'h8);

    // 3: one correct play, then a mismatch
    restart();
    play(4'b0001, 2);
    play(4'b0100, 2);
    wait_state(S_ERR, "err_wait");
    chk("err_flags",   {28'd0, pronto, acertou, errou, timeout}, 32'b1010);
    chk("err_igual",   {31'd0, db_igual},    32'd0);
    chk("err_addr",    {28'd0, db_contagem}, 32'd1);
    chk("err_jogada",  {28'd0, db_jogada},   32'h4);
    chk("err_memoria", {28'd0, db_memoria},  32'h2);

    // 4: a long press counts as exactly one play
    restart();
    wait_state(S_ESP, "hold_wait");
    push_exp(4'b0001);
    chaves = 4'b0001;
    repeat (10) step();
    chk("hold_state", {28'd0, db_estado},   {28'd0, S_SOLTA});
    chk("hold_addr",  {28'd0, db_contagem}, 32'd1);
    chaves = '0;
    step();
    chk("release_state", {28'd0, db_estado}, {28'd0, S_ESP});

    // 5: reset during the third play
    play(4'b0010, 2);
    wait_state(S_ESP, "rst_mid_wait");
    chaves = 4'b0100;
    step();
    chk("rst_mid_reg", {28'd0, db_estado}, {28'd0, S_REG});
    reset = 1'b0;
    #1;
    chk("rst_mid_state",  {28'd0, db_estado},   {28'd0, S_INI});
    chk("rst_mid_addr",   {28'd0, db_contagem}, 32'd0);
    chk("rst_mid_flags",  {28'd0, pronto, acertou, errou, timeout}, 32'd0);
    chk("rst_mid_jogada", {28'd0, db_jogada},   32'd0);
    chaves = '0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_state", {28'd0, db_estado}, {28'd0, S_INI});

`ifdef TIMEOUT_EN
    // 6: idle timeout, then a play on the expiry cycle
    restart();
    step();
    chk("tmo_espera", {28'd0, db_estado}, {28'd0, S_ESP});
    repeat (9) step();
    chk("tmo_before", {28'd0, db_estado}, {28'd0, S_ESP});
    step();
    chk("tmo_state", {28'd0, db_estado}, {28'd0, S_TMO});
    chk("tmo_flags", {28'd0, pronto, acertou, errou, timeout}, 32'b1011);
    restart();
    step();
    chk("race_espera", {28'd0, db_estado}, {28'd0, S_ESP});
    repeat (9) step();
    chk("race_before", {28'd0, db_estado}, {28'd0, S_ESP});
    push_exp(4'b0001);
    chaves = 4'b0001;
    step();
    chk("race_state", {28'd0, db_estado}, {28'd0, S_REG});
    step();
    chaves = '0;
    repeat (4) step();
`endif

    repeat (2) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
